// File: rtl/acuity_staircase_core_if.sv
// Handshake/bus bundle between the staircase core and the surrounding vision-test flow.
// The core takes the slave modport; the stimulus/response/result side takes the master modport.
interface acuity_staircase_core_if #(
    parameter int unsigned N_DIR     = 4,
    parameter int unsigned LEVEL_MAX = 12
);
    localparam int unsigned DIR_W = $clog2(N_DIR);
    localparam int unsigned LVL_W = $clog2(LEVEL_MAX + 1);

    logic             i_start;
    logic             i_abort;
    logic             i_resp_valid;
    logic [DIR_W-1:0] i_resp_dir;
    logic             o_resp_ready;
    logic             o_stim_valid;
    logic [DIR_W-1:0] o_stim_dir;
    logic [LVL_W-1:0] o_level;
    logic             o_busy;
    logic             o_result_valid;
    logic             i_result_ack;
    logic [LVL_W-1:0] o_result_level;
    logic [3:0]       o_result_reversals;
    logic [7:0]       o_result_trials;
    logic             o_result_ceiling;
    logic             o_aborted;

    modport slave (
        input  i_start, i_abort, i_resp_valid, i_resp_dir, i_result_ack,
        output o_resp_ready, o_stim_valid, o_stim_dir, o_level, o_busy,
               o_result_valid, o_result_level, o_result_reversals,
               o_result_trials, o_result_ceiling, o_aborted
    );

    modport master (
        output i_start, i_abort, i_resp_valid, i_resp_dir, i_result_ack,
        input  o_resp_ready, o_stim_valid, o_stim_dir, o_level, o_busy,
               o_result_valid, o_result_level, o_result_reversals,
               o_result_trials, o_result_ceiling, o_aborted
    );
endinterface

// File: rtl/acuity_staircase_core.sv
// Adaptive N-up/M-down acuity staircase: random optotype direction, response wait with
// optional timeout, level stepping with reversal/trial/ceiling termination and a result record.
module acuity_staircase_core #(
    parameter int unsigned N_DIR       = 4,
    parameter int unsigned LEVEL_MAX   = 12,
    parameter int unsigned START_LVL   = 0,
    parameter int unsigned UP_N        = 2,
    parameter int unsigned DOWN_N      = 2,
    parameter int unsigned MAX_REV     = 4,
    parameter int unsigned MAX_TRIALS  = 40,
    parameter int unsigned TIMEOUT_CYC = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic                     i_clk,
    input logic                     i_rst,
    acuity_staircase_core_if.slave  bus
);
    localparam int unsigned DIR_W  = $clog2(N_DIR);
    localparam int unsigned LVL_W  = $clog2(LEVEL_MAX + 1);
    localparam int unsigned STK_W  = 8;
    localparam int unsigned TO_W   = 32;
    localparam bit          TO_EN  = (TIMEOUT_CYC != 0);
    localparam int unsigned TO_END = TO_EN ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESENT = 3'd1,
        ST_WAIT    = 3'd2,
        ST_EVAL    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_t;

    state_t           state_q;
    step_t            last_q;
    logic [15:0]      lfsr_q;
    logic [LVL_W-1:0] level_q;
    logic [DIR_W-1:0] dir_q;
    logic [STK_W-1:0] ok_q;
    logic [STK_W-1:0] bad_q;
    logic [3:0]       rev_q;
    logic [7:0]       trials_q;
    logic [TO_W-1:0]  timer_q;
    logic             correct_q;
    logic             stim_valid_q;
    logic             resp_ready_q;
    logic             busy_q;
    logic             result_valid_q;
    logic             aborted_q;
    logic [LVL_W-1:0] res_level_q;
    logic [3:0]       res_rev_q;
    logic [7:0]       res_trials_q;
    logic             res_ceil_q;

    // Next-trial bookkeeping, consumed only in EVAL
    step_t            last_nx;
    logic [STK_W-1:0] ok_nx;
    logic [STK_W-1:0] bad_nx;
    logic [LVL_W-1:0] level_nx;
    logic [3:0]       rev_nx;
    logic [7:0]       trials_nx;
    logic             req_up;
    logic             req_dn;
    logic             ceiling_hit;
    logic             step_up;
    logic             step_dn;
    logic             finish_test;

    logic lfsr_fb;
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        ok_nx     = ok_q;
        bad_nx    = bad_q;
        req_up    = 1'b0;
        req_dn    = 1'b0;
        level_nx  = level_q;
        rev_nx    = rev_q;
        last_nx   = last_q;
        trials_nx = (trials_q == 8'hFF) ? trials_q : trials_q + 8'd1;

        if (correct_q) begin
            bad_nx = '0;
            ok_nx  = ok_q + STK_W'(1);
            if (ok_nx == STK_W'(UP_N)) begin
                ok_nx  = '0;
                req_up = 1'b1;
            end
        end else begin
            ok_nx  = '0;
            bad_nx = bad_q + STK_W'(1);
            if (bad_nx == STK_W'(DOWN_N)) begin
                bad_nx = '0;
                req_dn = 1'b1;
            end
        end

        // A down request at level 0 is swallowed and does not count as a step
        ceiling_hit = req_up && (level_q == LVL_W'(LEVEL_MAX));
        step_up     = req_up && !ceiling_hit;
        step_dn     = req_dn && (level_q != '0);

        if (step_up) begin
            level_nx = level_q + LVL_W'(1);
            last_nx  = STEP_UP;
            if (last_q == STEP_DOWN && rev_q != 4'hF) rev_nx = rev_q + 4'd1;
        end else if (step_dn) begin
            level_nx = level_q - LVL_W'(1);
            last_nx  = STEP_DOWN;
            if (last_q == STEP_UP && rev_q != 4'hF) rev_nx = rev_q + 4'd1;
        end

        finish_test = ceiling_hit || (rev_nx == 4'(MAX_REV)) ||
                      (trials_nx == 8'(MAX_TRIALS));
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= ST_IDLE;
            last_q         <= STEP_NONE;
            lfsr_q         <= LFSR_SEED;
            level_q        <= '0;
            dir_q          <= '0;
            ok_q           <= '0;
            bad_q          <= '0;
            rev_q          <= '0;
            trials_q       <= '0;
            timer_q        <= '0;
            correct_q      <= 1'b0;
            stim_valid_q   <= 1'b0;
            resp_ready_q   <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            aborted_q      <= 1'b0;
            res_level_q    <= '0;
            res_rev_q      <= '0;
            res_trials_q   <= '0;
            res_ceil_q     <= 1'b0;
        end else begin
            lfsr_q    <= {lfsr_q[14:0], lfsr_fb};
            aborted_q <= 1'b0;

            if (bus.i_abort && state_q != ST_IDLE) begin
                state_q        <= ST_IDLE;
                aborted_q      <= 1'b1;
                stim_valid_q   <= 1'b0;
                resp_ready_q   <= 1'b0;
                result_valid_q <= 1'b0;
                busy_q         <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.i_start && !bus.i_abort) begin
                            level_q  <= LVL_W'(START_LVL);
                            ok_q     <= '0;
                            bad_q    <= '0;
                            rev_q    <= '0;
                            trials_q <= '0;
                            last_q   <= STEP_NONE;
                            busy_q   <= 1'b1;
                            state_q  <= ST_PRESENT;
                        end
                    end
                    ST_PRESENT: begin
                        dir_q        <= lfsr_q[DIR_W-1:0];
                        timer_q      <= '0;
                        stim_valid_q <= 1'b1;
                        resp_ready_q <= 1'b1;
                        state_q      <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // A response arriving on the final timeout cycle still counts
                        if (bus.i_resp_valid && resp_ready_q) begin
                            correct_q    <= (bus.i_resp_dir == dir_q);
                            stim_valid_q <= 1'b0;
                            resp_ready_q <= 1'b0;
                            state_q      <= ST_EVAL;
                        end else if (TO_EN && timer_q == TO_W'(TO_END)) begin
                            correct_q    <= 1'b0;
                            stim_valid_q <= 1'b0;
                            resp_ready_q <= 1'b0;
                            state_q      <= ST_EVAL;
                        end else begin
                            timer_q <= timer_q + TO_W'(1);
                        end
                    end
                    ST_EVAL: begin
                        ok_q     <= ok_nx;
                        bad_q    <= bad_nx;
                        level_q  <= level_nx;
                        rev_q    <= rev_nx;
                        last_q   <= last_nx;
                        trials_q <= trials_nx;
                        if (finish_test) begin
                            res_level_q    <= level_nx;
                            res_rev_q      <= rev_nx;
                            res_trials_q   <= trials_nx;
                            res_ceil_q     <= ceiling_hit;
                            result_valid_q <= 1'b1;
                            state_q        <= ST_DONE;
                        end else begin
                            state_q <= ST_PRESENT;
                        end
                    end
                    ST_DONE: begin
                        if (bus.i_result_ack) begin
                            result_valid_q <= 1'b0;
                            busy_q         <= 1'b0;
                            state_q        <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_resp_ready       = resp_ready_q;
    assign bus.o_stim_valid       = stim_valid_q;
    assign bus.o_stim_dir         = dir_q;
    assign bus.o_level            = level_q;
    assign bus.o_busy             = busy_q;
    assign bus.o_result_valid     = result_valid_q;
    assign bus.o_result_level     = res_level_q;
    assign bus.o_result_reversals = res_rev_q;
    assign bus.o_result_trials    = res_trials_q;
    assign bus.o_result_ceiling   = res_ceil_q;
    assign bus.o_aborted          = aborted_q;
endmodule

// File: tb/tb_acuity_staircase_core.sv
// Directed bench for acuity_staircase_core: three parameterisations (default, timeout,
// 8-direction 3-up/1-down) driven through a linear sequence of steps.
module tb_acuity_staircase_core;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    logic [7:0] seen;

    acuity_staircase_core_if #(.N_DIR(4), .LEVEL_MAX(12)) ia ();
    acuity_staircase_core_if #(.N_DIR(4), .LEVEL_MAX(12)) ib ();
    acuity_staircase_core_if #(.N_DIR(8), .LEVEL_MAX(5))  ic ();

    acuity_staircase_core u_a (.i_clk(clk), .i_rst(rst_n), .bus(ia));

    acuity_staircase_core #(
        .START_LVL(1), .UP_N(1), .DOWN_N(1), .MAX_TRIALS(2), .TIMEOUT_CYC(10)
    ) u_b (.i_clk(clk), .i_rst(rst_n), .bus(ib));

    acuity_staircase_core #(
        .N_DIR(8), .LEVEL_MAX(5), .UP_N(3), .DOWN_N(1)
    ) u_c (.i_clk(clk), .i_rst(rst_n), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic answer_a(input bit good);
        int n = 0;
        while (ia.o_stim_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        chk("a_stim_seen", 32'(ia.o_stim_valid), 32'd1);
        ia.i_resp_valid = 1'b1;
        ia.i_resp_dir   = good ? ia.o_stim_dir : ia.o_stim_dir + 2'd1;
        tick(1);
        ia.i_resp_valid = 1'b0;
    endtask

    task automatic answer_c(input bit good);
        int n = 0;
        while (ic.o_stim_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        chk("c_stim_seen", 32'(ic.o_stim_valid), 32'd1);
        seen[ic.o_stim_dir] = 1'b1;
        ic.i_resp_valid = 1'b1;
        ic.i_resp_dir   = good ? ic.o_stim_dir : ic.o_stim_dir + 3'd1;
        tick(1);
        ic.i_resp_valid = 1'b0;
    endtask

    task automatic wait_result_a();
        int n = 0;
        while (ia.o_result_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        chk("a_result_seen", 32'(ia.o_result_valid), 32'd1);
    endtask

    task automatic wait_result_c();
        int n = 0;
        while (ic.o_result_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        chk("c_result_seen", 32'(ic.o_result_valid), 32'd1);
    endtask

    task automatic ack_a();
        ia.i_result_ack = 1'b1;
        tick(1);
        ia.i_result_ack = 1'b0;
        chk("a_ack_valid_drop", 32'(ia.o_result_valid), 32'd0);
        chk("a_ack_busy_drop", 32'(ia.o_busy), 32'd0);
    endtask

    task automatic ack_c();
        ic.i_result_ack = 1'b1;
        tick(1);
        ic.i_result_ack = 1'b0;
        chk("c_ack_busy_drop", 32'(ic.o_busy), 32'd0);
    endtask

    task automatic start_a();
        ia.i_start = 1'b1;
        tick(1);
        ia.i_start = 1'b0;
    endtask

    task automatic start_c();
        ic.i_start = 1'b1;
        tick(1);
        ic.i_start = 1'b0;
    endtask

    initial begin
        int n;
        seen  = '0;
        rst_n = 1'b0;
        {ia.i_start, ia.i_abort, ia.i_resp_valid, ia.i_result_ack} = '0;
        {ib.i_start, ib.i_abort, ib.i_resp_valid, ib.i_result_ack} = '0;
        {ic.i_start, ic.i_abort, ic.i_resp_valid, ic.i_result_ack} = '0;
        ia.i_resp_dir = '0;
        ib.i_resp_dir = '0;
        ic.i_resp_dir = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        chk("rst_busy", 32'(ia.o_busy), 32'd0);
        chk("rst_stim_valid", 32'(ia.o_stim_valid), 32'd0);
        chk("rst_resp_ready", 32'(ia.o_resp_ready), 32'd0);
        chk("rst_level", 32'(ia.o_level), 32'd0);
        chk("rst_result_valid", 32'(ia.o_result_valid), 32'd0);
        chk("rst_aborted", 32'(ia.o_aborted), 32'd0);

        // Always correct: +1 every 2 trials, ceiling request on trial 26
        start_a();
        chk("a1_busy", 32'(ia.o_busy), 32'd1);
        for (int i = 0; i < 24; i++) answer_a(1'b1);
        tick(1);
        chk("a1_level_24", 32'(ia.o_level), 32'd12);
        answer_a(1'b1);
        answer_a(1'b1);
        wait_result_a();
        chk("a1_res_level", 32'(ia.o_result_level), 32'd12);
        chk("a1_res_rev", 32'(ia.o_result_reversals), 32'd0);
        chk("a1_res_trials", 32'(ia.o_result_trials), 32'd26);
        chk("a1_res_ceiling", 32'(ia.o_result_ceiling), 32'd1);
        chk("a1_level_held", 32'(ia.o_level), 32'd12);
        tick(3);
        chk("a1_valid_held", 32'(ia.o_result_valid), 32'd1);
        chk("a1_busy_done", 32'(ia.o_busy), 32'd1);
        ack_a();
        chk("a1_record_kept", 32'(ia.o_result_trials), 32'd26);

        // C,C,W,W pattern: reversal on every step after the first
        start_a();
        for (int i = 0; i < 10; i++) begin
            answer_a((i % 4) < 2);
            if (i == 1) begin tick(1); chk("a2_level_t2", 32'(ia.o_level), 32'd1); end
            if (i == 3) begin tick(1); chk("a2_level_t4", 32'(ia.o_level), 32'd0); end
        end
        wait_result_a();
        chk("a2_res_level", 32'(ia.o_result_level), 32'd1);
        chk("a2_res_rev", 32'(ia.o_result_reversals), 32'd4);
        chk("a2_res_trials", 32'(ia.o_result_trials), 32'd10);
        chk("a2_res_ceiling", 32'(ia.o_result_ceiling), 32'd0);
        tick(2);
        chk("a2_valid_held", 32'(ia.o_result_valid), 32'd1);
        ack_a();

        // All wrong: level pinned at 0, test ends on trial limit
        start_a();
        for (int i = 0; i < 40; i++) answer_a(1'b0);
        wait_result_a();
        chk("a3_res_level", 32'(ia.o_result_level), 32'd0);
        chk("a3_res_rev", 32'(ia.o_result_reversals), 32'd0);
        chk("a3_res_trials", 32'(ia.o_result_trials), 32'd40);
        chk("a3_res_ceiling", 32'(ia.o_result_ceiling), 32'd0);
        ack_a();

        // Abort during WAIT, then start+abort together in IDLE
        start_a();
        n = 0;
        while (ia.o_stim_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        chk("a4_in_wait", 32'(ia.o_resp_ready), 32'd1);
        ia.i_abort = 1'b1;
        tick(1);
        ia.i_abort = 1'b0;
        chk("a4_aborted_pulse", 32'(ia.o_aborted), 32'd1);
        chk("a4_busy", 32'(ia.o_busy), 32'd0);
        chk("a4_stim_valid", 32'(ia.o_stim_valid), 32'd0);
        chk("a4_resp_ready", 32'(ia.o_resp_ready), 32'd0);
        chk("a4_result_valid", 32'(ia.o_result_valid), 32'd0);
        tick(1);
        chk("a4_aborted_end", 32'(ia.o_aborted), 32'd0);
        chk("a4_no_result", 32'(ia.o_result_valid), 32'd0);
        ia.i_start = 1'b1;
        ia.i_abort = 1'b1;
        tick(1);
        ia.i_start = 1'b0;
        ia.i_abort = 1'b0;
        chk("a5_idle_busy", 32'(ia.o_busy), 32'd0);
        chk("a5_no_pulse", 32'(ia.o_aborted), 32'd0);
        tick(2);
        chk("a5_still_idle", 32'(ia.o_stim_valid), 32'd0);

        // Timeout = 10: first trial times out (wrong -> down), second answered on cycle 10
        ib.i_start = 1'b1;
        tick(1);
        ib.i_start = 1'b0;
        n = 0;
        while (ib.o_stim_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        chk("b_stim_seen", 32'(ib.o_stim_valid), 32'd1);
        tick(9);
        chk("b_wait_cycle9", 32'(ib.o_stim_valid), 32'd1);
        tick(1);
        chk("b_eval_at_10", 32'(ib.o_stim_valid), 32'd0);
        tick(1);
        chk("b_timeout_wrong", 32'(ib.o_level), 32'd0);
        n = 0;
        while (ib.o_stim_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        chk("b_stim2_seen", 32'(ib.o_stim_valid), 32'd1);
        tick(9);
        chk("b2_wait_cycle9", 32'(ib.o_resp_ready), 32'd1);
        ib.i_resp_valid = 1'b1;
        ib.i_resp_dir   = ib.o_stim_dir;
        tick(1);
        ib.i_resp_valid = 1'b0;
        chk("b2_eval", 32'(ib.o_stim_valid), 32'd0);
        tick(1);
        chk("b2_result_valid", 32'(ib.o_result_valid), 32'd1);
        chk("b2_res_level", 32'(ib.o_result_level), 32'd1);
        chk("b2_res_rev", 32'(ib.o_result_reversals), 32'd1);
        chk("b2_res_trials", 32'(ib.o_result_trials), 32'd2);
        chk("b2_res_ceiling", 32'(ib.o_result_ceiling), 32'd0);
        ib.i_result_ack = 1'b1;
        tick(1);
        ib.i_result_ack = 1'b0;
        chk("b2_busy_drop", 32'(ib.o_busy), 32'd0);

        // 8 directions, 3-up/1-down: all-wrong run first for direction coverage
        start_c();
        for (int i = 0; i < 40; i++) answer_c(1'b0);
        wait_result_c();
        chk("c1_res_level", 32'(ic.o_result_level), 32'd0);
        chk("c1_res_trials", 32'(ic.o_result_trials), 32'd40);
        ack_c();

        start_c();
        for (int i = 0; i < 11; i++) begin
            answer_c((i % 4) != 3);
            if (i == 1) begin tick(1); chk("c2_level_t2", 32'(ic.o_level), 32'd0); end
            if (i == 2) begin tick(1); chk("c2_level_t3", 32'(ic.o_level), 32'd1); end
            if (i == 3) begin tick(1); chk("c2_level_t4", 32'(ic.o_level), 32'd0); end
        end
        wait_result_c();
        chk("c2_res_level", 32'(ic.o_result_level), 32'd1);
        chk("c2_res_rev", 32'(ic.o_result_reversals), 32'd4);
        chk("c2_res_trials", 32'(ic.o_result_trials), 32'd11);
        chk("c2_res_ceiling", 32'(ic.o_result_ceiling), 32'd0);
        ack_c();
        chk("c_dir_coverage", 32'(seen), 32'hFF);

        // Async reset mid-WAIT with a non-zero level and a stale record
        start_c();
        for (int i = 0; i < 3; i++) answer_c(1'b1);
        tick(1);
        chk("c3_level_up", 32'(ic.o_level), 32'd1);
        n = 0;
        while (ic.o_stim_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        chk("c3_in_wait", 32'(ic.o_stim_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("c3_rst_stim_valid", 32'(ic.o_stim_valid), 32'd0);
        chk("c3_rst_resp_ready", 32'(ic.o_resp_ready), 32'd0);
        chk("c3_rst_stim_dir", 32'(ic.o_stim_dir), 32'd0);
        chk("c3_rst_level", 32'(ic.o_level), 32'd0);
        chk("c3_rst_busy", 32'(ic.o_busy), 32'd0);
        chk("c3_rst_result_valid", 32'(ic.o_result_valid), 32'd0);
        chk("c3_rst_res_level", 32'(ic.o_result_level), 32'd0);
        chk("c3_rst_res_rev", 32'(ic.o_result_reversals), 32'd0);
        chk("c3_rst_res_trials", 32'(ic.o_result_trials), 32'd0);
        chk("c3_rst_res_ceiling", 32'(ic.o_result_ceiling), 32'd0);
        chk("c3_rst_aborted", 32'(ic.o_aborted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        chk("c3_post_rst_idle", 32'(ic.o_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
